// File: rtl/irrigation_pkg.sv
// Shared state encoding and width helper for the irrigation cycle sequencer.
package irrigation_pkg;
  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    PRIME = 3'd1,
    WATER = 3'd2,
    SOAK  = 3'd3,
    FAULT = 3'd4
  } state_e;

  // Bits needed to hold values 0..v-1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/moisture_debounce.sv
// Two-flop synchronizer on the soil sensor followed by a tick-based debounce.
module moisture_debounce
  import irrigation_pkg::*;
#(
  parameter int SENSE_TICKS = 4
) (
  input  logic clock,
  input  logic preset,
  input  logic tick,
  input  logic dry_raw,
  output logic dry_stable
);
  localparam int RW = clog2(SENSE_TICKS + 1);

  logic          sync1_q, dry_s_q, stable_q;
  logic [RW-1:0] run_q;

  // A run of SENSE_TICKS disagreeing ticks flips the stable level.
  always_ff @(posedge clock or posedge preset) begin
    if (preset) begin
      sync1_q  <= 1'b0;
      dry_s_q  <= 1'b0;
      stable_q <= 1'b0;
      run_q    <= '0;
    end else begin
      sync1_q <= dry_raw;
      dry_s_q <= sync1_q;
      if (tick) begin
        if (dry_s_q != stable_q) begin
          if (run_q == RW'(SENSE_TICKS - 1)) begin
            stable_q <= dry_s_q;
            run_q    <= '0;
          end else begin
            run_q <= run_q + 1'b1;
          end
        end else begin
          run_q <= '0;
        end
      end
    end
  end

  assign dry_stable = stable_q;
endmodule

// File: rtl/irrigation_cycle_ctrl.sv
// Watering-cycle sequencer: prime / water / soak with a bounded cycle count per demand.
module irrigation_cycle_ctrl
  import irrigation_pkg::*;
#(
  parameter int SENSE_TICKS = 4,
  parameter int WATER_TICKS = 10,
  parameter int SOAK_TICKS  = 5,
  parameter int MAX_CYCLES  = 3
) (
  input  logic                             clock,
  input  logic                             preset,
  input  logic                             tick,
  input  logic                             dry_raw,
  input  logic                             manual_req,
  input  logic                             stop,
  output logic                             valve_on,
  output logic                             pump_on,
  output logic                             cycle_toggle,
  output logic [clog2(MAX_CYCLES+1)-1:0]   cycles_done,
  output logic [STATE_W-1:0]               state,
  output logic                             fault
);
  localparam int CW = clog2(((WATER_TICKS > SOAK_TICKS) ? WATER_TICKS : SOAK_TICKS) + 1);
  localparam int YW = clog2(MAX_CYCLES + 1);

  logic          dry_stable;
  state_e        state_q, state_d;
  logic [CW-1:0] tcnt_q, tcnt_d;
  logic [YW-1:0] cyc_q, cyc_d;
  logic          tog_d;
  logic          valve_q, pump_q, tog_q, fault_q;

  moisture_debounce #(.SENSE_TICKS(SENSE_TICKS)) u_deb (
    .clock, .preset, .tick, .dry_raw, .dry_stable
  );

  // Down-counter preload: remaining ticks after the first one in the new state.
  function automatic logic [CW-1:0] entry_load(input state_e s);
    case (s)
      WATER:   return CW'(WATER_TICKS - 1);
      SOAK:    return CW'(SOAK_TICKS - 1);
      default: return '0;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    cyc_d   = cyc_q;
    tog_d   = 1'b0;
    case (state_q)
      IDLE:  if (!stop && (dry_stable || manual_req)) state_d = PRIME;
      FAULT: if (stop) begin state_d = IDLE; cyc_d = '0; end
      PRIME, WATER, SOAK: begin
        // stop wins over a same-cycle period completion
        if (stop) begin
          state_d = IDLE;
          cyc_d   = '0;
        end else if (tick) begin
          if (tcnt_q != '0) tcnt_d = tcnt_q - 1'b1;
          else begin
            case (state_q)
              PRIME: state_d = WATER;
              WATER: begin
                state_d = SOAK;
                tog_d   = 1'b1;
                cyc_d   = cyc_q + 1'b1;
              end
              default: begin
                if (!dry_stable) begin
                  state_d = IDLE;
                  cyc_d   = '0;
                end else if (cyc_q < YW'(MAX_CYCLES)) state_d = PRIME;
                else state_d = FAULT;
              end
            endcase
          end
        end
      end
      default: begin
        state_d = IDLE;
        cyc_d   = '0;
      end
    endcase
    if (state_d != state_q) tcnt_d = entry_load(state_d);
  end

  always_ff @(posedge clock or posedge preset) begin
    if (preset) begin
      state_q <= IDLE;
      tcnt_q  <= '0;
      cyc_q   <= '0;
      valve_q <= 1'b0;
      pump_q  <= 1'b0;
      tog_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      cyc_q   <= cyc_d;
      valve_q <= (state_d == WATER);
      pump_q  <= (state_d == PRIME) || (state_d == WATER);
      tog_q   <= tog_d;
      fault_q <= (state_d == FAULT);
    end
  end

  assign state        = state_q;
  assign valve_on     = valve_q;
  assign pump_on      = pump_q;
  assign cycle_toggle = tog_q;
  assign cycles_done  = cyc_q;
  assign fault        = fault_q;
endmodule

// File: tb/tb_irrigation_cycle_ctrl.sv
// Directed plan scenarios plus random traffic against a phase/elapsed-tick reference model.
module tb_irrigation_cycle_ctrl;
  localparam int ST = 4, WT = 10, SK = 5, MC = 3;

  logic       clock = 1'b0, preset = 1'b1, tick = 1'b1, dry_raw = 1'b0;
  logic       manual_req = 1'b0, stop = 1'b0;
  logic       valve_on, pump_on, cycle_toggle, fault;
  logic [1:0] cycles_done;
  logic [2:0] state;
  logic [8:0] dut_out;

  always #5 clock = ~clock;

  irrigation_cycle_ctrl #(.SENSE_TICKS(ST), .WATER_TICKS(WT), .SOAK_TICKS(SK), .MAX_CYCLES(MC)) dut (
    .clock(clock), .preset(preset), .tick(tick), .dry_raw(dry_raw),
    .manual_req(manual_req), .stop(stop), .valve_on(valve_on), .pump_on(pump_on),
    .cycle_toggle(cycle_toggle), .cycles_done(cycles_done), .state(state), .fault(fault)
  );

  assign dut_out = {state, valve_on, pump_on, cycle_toggle, cycles_done, fault};

  int n_chk = 0, n_fail = 0;
  int m_s1, m_s2, m_stab, m_run, m_ph, m_el, m_cyc, m_tog;
  int tog_cnt, valve_cnt, soak_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [8:0] m_out();
    return {3'(m_ph), m_ph == 2, (m_ph == 1) || (m_ph == 2), m_tog != 0, 2'(m_cyc), m_ph == 4};
  endfunction

  function automatic int dur(input int ph);
    return (ph == 1) ? 1 : (ph == 2) ? WT : SK;
  endfunction

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_stab = 0; m_run = 0;
    m_ph = 0; m_el = 0; m_cyc = 0; m_tog = 0;
  endtask

  task automatic enter(input int ph);
    m_ph = ph;
    m_el = 0;
  endtask

  // One rising edge: sequence first (sees old debounced level), then sensor path.
  task automatic model_clk();
    if (preset) begin model_reset(); return; end
    m_tog = 0;
    if (m_ph == 0) begin
      if (!stop && (m_stab != 0 || manual_req)) enter(1);
    end else if (m_ph == 4) begin
      if (stop) begin enter(0); m_cyc = 0; end
    end else if (stop) begin
      enter(0); m_cyc = 0;
    end else if (tick) begin
      m_el++;
      if (m_el == dur(m_ph)) begin
        if (m_ph == 1) enter(2);
        else if (m_ph == 2) begin m_tog = 1; m_cyc++; enter(3); end
        else if (m_stab == 0) begin enter(0); m_cyc = 0; end
        else if (m_cyc < MC) enter(1);
        else enter(4);
      end
    end
    if (tick) begin
      if (m_s2 != m_stab) begin
        m_run++;
        if (m_run == ST) begin m_stab = m_s2; m_run = 0; end
      end else m_run = 0;
    end
    m_s2 = m_s1;
    m_s1 = int'(dry_raw);
  endtask

  task automatic step();
    @(posedge clock);
    model_clk();
    #1;
    chk("cycle", dut_out, m_out());
    tog_cnt   += int'(cycle_toggle);
    valve_cnt += int'(valve_on);
    soak_cnt  += int'(state == 3'd3);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_state(input string tag, input logic [2:0] tgt, input int limit);
    for (int i = 0; i < limit && state != tgt; i++) step();
    chk(tag, 32'(state), 32'(tgt));
  endtask

  task automatic do_reset();
    preset = 1'b1; manual_req = 1'b0; stop = 1'b0; dry_raw = 1'b0; tick = 1'b1;
    @(posedge clock); #1;
    model_reset();
    preset = 1'b0;
    tog_cnt = 0; valve_cnt = 0; soak_cnt = 0;
  endtask

  initial begin
    model_reset();
    #3;
    chk("reset_outputs", dut_out, 9'd0);
    do_reset();

    // 1 + 3: continuous dry demand
    dry_raw = 1'b1;
    steps(6);
    chk("t1_idle_at_6", 32'(state), 32'd0);
    step();
    chk("t1_prime_at_7", 32'(state), 32'd1);
    valve_cnt = 0; tog_cnt = 0;
    steps(11);
    chk("t1_valve_clocks", valve_cnt, WT);
    chk("t1_toggles", tog_cnt, 1);
    chk("t1_cycles", 32'(cycles_done), 32'd1);
    chk("t1_in_soak", 32'(state), 32'd3);
    wait_state("t3_fault", 3'd4, 200);
    chk("t3_toggles", tog_cnt, MC);
    chk("t3_outs", {fault, valve_on, pump_on}, 3'b100);
    stop = 1'b1; step(); stop = 1'b0;
    chk("t3_stop_idle", {state, fault, cycles_done}, 6'd0);

    // 2: demand clears during first water
    do_reset();
    dry_raw = 1'b1;
    wait_state("t2_water", 3'd2, 40);
    dry_raw = 1'b0;
    soak_cnt = 0; tog_cnt = 0;
    wait_state("t2_idle", 3'd0, 60);
    chk("t2_soak_clocks", soak_cnt, SK);
    chk("t2_toggles", tog_cnt, 1);
    chk("t2_cycles", 32'(cycles_done), 32'd0);

    // 4: stop on the final water tick
    do_reset();
    dry_raw = 1'b1;
    wait_state("t4_water", 3'd2, 40);
    steps(WT - 1);
    tog_cnt = 0;
    stop = 1'b1; step(); stop = 1'b0;
    chk("t4_stop", {state, valve_on, cycle_toggle, cycles_done}, 7'd0);
    chk("t4_no_toggle", tog_cnt, 0);

    // 5: asynchronous preset between edges
    do_reset();
    dry_raw = 1'b1;
    wait_state("t5_water", 3'd2, 40);
    steps(3);
    #2 preset = 1'b1;
    #1 chk("t5_async_zero", dut_out, 9'd0);
    model_reset();
    dry_raw = 1'b0;
    #2 preset = 1'b0;
    steps(12);
    chk("t5_stays_idle", 32'(state), 32'd0);

    // 6: short dry glitch, then manual start
    do_reset();
    dry_raw = 1'b1; steps(3);
    dry_raw = 1'b0; steps(10);
    chk("t6_no_start", 32'(state), 32'd0);
    manual_req = 1'b1; step(); manual_req = 1'b0;
    chk("t6_manual_prime", 32'(state), 32'd1);
    tog_cnt = 0;
    wait_state("t6_water", 3'd2, 5);
    steps(2);
    manual_req = 1'b1; step(); manual_req = 1'b0;
    chk("t6_manual_ignored", 32'(state), 32'd2);
    wait_state("t6_back_idle", 3'd0, 40);
    chk("t6_toggles", tog_cnt, 1);

    // random traffic, model compared every clock
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      tick       = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 59) == 0) dry_raw = ~dry_raw;
      manual_req = ($urandom_range(0, 29) == 0);
      stop       = ($urandom_range(0, 79) == 0);
      preset     = ($urandom_range(0, 599) == 0);
      step();
    end
    preset = 1'b0; stop = 1'b0; manual_req = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/irrigation_cycle_ctrl.md
Name: irrigation_cycle_ctrl

Overview:
Watering-cycle sequencer for the automated irrigation controller. It debounces the soil-dryness sensor and runs a bounded pump-prime / water / soak sequence. It drives the valve and pump enables and emits a one-clock cycle_toggle pulse per completed watering period. That pulse drives the T input of the downstream toggle flip-flop cycle-count/indicator stage.

Parameters:
SENSE_TICKS, 4, consecutive ticks dry_s must hold a level before dry_stable follows it (>=1)
WATER_TICKS, 10, ticks spent in WATER per cycle (>=1)
SOAK_TICKS, 5, ticks spent in SOAK after each watering (>=1)
MAX_CYCLES, 3, watering cycles allowed per demand before FAULT (>=1)

Ports:
clock  in  1  system clock, rising edge
preset  in  1  reset, asynchronous, active-high
tick  in  1  one-clock timebase enable; all timing counts only on clocks where tick=1
dry_raw  in  1  asynchronous soil-dry sensor, 1 = dry
manual_req  in  1  one-clock manual start request
stop  in  1  operator abort / fault acknowledge
valve_on  out  1  irrigation valve enable
pump_on  out  1  pump enable
cycle_toggle  out  1  one-clock pulse per completed WATER period; feeds downstream T flip-flop
cycles_done  out  clog2(MAX_CYCLES+1)  completed cycles in the current demand
state  out  3  current FSM state code
fault  out  1  sensor/water-supply fault flag

Behaviour:
- Reset (preset=1, async): state=IDLE; valve_on, pump_on, cycle_toggle, fault, cycles_done=0; synchronizer, debounce and tick counters=0; dry_stable=0.
- Reset assertion mid-operation takes effect immediately and does not wait for a clock edge. Outputs go to 0 without waiting for an edge.
- Synchronizer: dry_raw passes through 2 flops to give dry_s.
- Debounce: on each tick where dry_s != dry_stable, the run counter increments. Otherwise it clears. When the counter reaches SENSE_TICKS, dry_stable takes dry_s and the counter clears. Clocks without tick hold the counter.
- State codes: IDLE=0, PRIME=1, WATER=2, SOAK=3, FAULT=4. All outputs are registered and update on the same edge as state.
- Decoded outputs: pump_on=1 in PRIME and WATER. valve_on=1 in WATER only. fault=1 in FAULT only.
- IDLE:
  - dry_stable=1 or manual_req=1 -> PRIME.
  - The tick counter is loaded on every state entry.
- PRIME: lasts one tick. On the next tick -> WATER.
- WATER:
  - On the WATER_TICKS-th tick -> SOAK.
  - On that same edge: cycle_toggle=1 for exactly one clock, and cycles_done increments.
- SOAK: on the SOAK_TICKS-th tick:
  - dry_stable=0 -> IDLE, cycles_done=0.
  - dry_stable=1 and cycles_done<MAX_CYCLES -> PRIME.
  - dry_stable=1 and cycles_done==MAX_CYCLES -> FAULT.
- FAULT: outputs off. Only stop=1 exits -> IDLE, with cycles_done=0.
- stop=1 in PRIME/WATER/SOAK -> IDLE on next edge with cycles_done=0.
  - stop has priority over a same-cycle tick completion, so no cycle_toggle pulse and no increment.
  - stop in IDLE has no effect, and stop suppresses a same-cycle start.
- manual_req outside IDLE is ignored.
- A manual start with dry_stable=0 runs one cycle, then returns to IDLE at the end of SOAK.
- Start latency: a dry_raw edge reaches dry_stable after 2 clocks plus SENSE_TICKS ticks. IDLE->PRIME follows one clock later.
- cycle_toggle is never high on two consecutive clocks. It is never high while preset=1.

Decomposition:
- Package irrigation_pkg: state encoding constants (IDLE..FAULT), state width (3), and a clog2 helper function for counter widths.
- Sub-module moisture_debounce: the synchronizer plus debounce counter, producing dry_stable.
- The FSM, tick counter and cycles_done stay in the top module.

Test Plan:
All scenarios use default parameters and tick=1 every clock unless stated.
1. dry_raw=1 from reset release -> dry_stable at clock 6, PRIME at clock 7, valve_on=1 for exactly 10 clocks. A single cycle_toggle pulse on WATER->SOAK, cycles_done=1.
2. dry_raw=0 during the first WATER -> cycle completes. SOAK 5 clocks -> IDLE, cycles_done=0, exactly 1 cycle_toggle pulse total.
3. dry_raw held 1 throughout -> 3 WATER periods and 3 cycle_toggle pulses, then FAULT with fault=1, valve_on=0, pump_on=0. A one-clock stop gives IDLE, fault=0, cycles_done=0.
4. stop asserted on the 10th WATER tick -> IDLE next clock, no cycle_toggle pulse, cycles_done=0, valve_on=0.
5. preset pulsed asynchronously (between edges) mid-WATER -> all outputs 0 before the next clock edge. After release the block stays in IDLE until dry_stable or manual_req.
6. dry_raw high for 3 ticks then low -> no start. Then a manual_req pulse in IDLE -> PRIME next clock, one full cycle, then IDLE. A manual_req during WATER is ignored.
